// File: rtl/fir_pkg.sv
// Shared definitions for the fir block and its output stream buffer.
package fir_pkg;

    localparam int P_DATA_WIDTH = 32;
    localparam int P_LEN_WIDTH  = 16;

    // One buffered stream beat at the default data width.
    typedef struct packed {
        logic                    tlast;
        logic [P_DATA_WIDTH-1:0] tdata;
    } fir_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_out_regfile.sv
// Storage array for the output buffer: one synchronous write port, one asynchronous read port.
module fir_out_regfile
    import fir_pkg::*;
#(
    parameter int pDEPTH = 16,
    parameter int pWIDTH = P_DATA_WIDTH + 1,
    localparam int AW    = clog2(pDEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [pWIDTH-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [pWIDTH-1:0] rd_data
);

    // Contents are never reset; occupancy tracking decides what is valid.
    logic [pWIDTH-1:0] mem_q [pDEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fir_out_buffer.sv
// Elastic AXI-Stream FIFO behind the fir master stream, with per-frame statistics.
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = P_DATA_WIDTH,
    parameter int pDEPTH      = 16,
    parameter int pLEN_WIDTH  = P_LEN_WIDTH
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    output logic [clog2(pDEPTH):0]   level,
    output logic                     frame_done,
    output logic [pLEN_WIDTH-1:0]    frame_cnt,
    output logic [pLEN_WIDTH-1:0]    last_len
);

    localparam int AW = clog2(pDEPTH);
    localparam int LW = AW + 1;
    localparam int EW = pDATA_WIDTH + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [pLEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [pLEN_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [pLEN_WIDTH-1:0] last_len_q, last_len_d;
    logic                  frame_done_q, frame_done_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] rd_entry;

    // Ready depends only on registered occupancy, never on m_tready.
    assign s_tready = (level_q != LW'(pDEPTH)) & ~axis_rst;
    assign m_tvalid = (level_q != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    fir_out_regfile #(
        .pDEPTH (pDEPTH),
        .pWIDTH (EW)
    ) u_regfile (
        .clk     (axis_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data ({s_tlast, s_tdata}),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign m_tlast = rd_entry[EW-1];
    assign m_tdata = rd_entry[pDATA_WIDTH-1:0];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        beat_cnt_d   = beat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        last_len_d   = last_len_q;
        frame_done_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Beat counting saturates so an endless frame still reports the maximum length.
        if (pop) begin
            if (m_tlast) begin
                last_len_d   = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
                beat_cnt_d   = '0;
                frame_cnt_d  = frame_cnt_q + 1'b1;
                frame_done_d = 1'b1;
            end else if (!(&beat_cnt_q)) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            beat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            last_len_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            last_len_q   <= last_len_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign level      = level_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign last_len   = last_len_q;

endmodule
